change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Downstream of the vending-controller FSM. Consumes its per-transaction result: a purchase flag plus a 2-bit change code (R0/R5/R10/R15).
- Queues each result, then drives the product vend motor for a fixed time.
- Pays change as 5-unit coins, one at a time, over a four-phase req/ack handshake with the coin hopper.
- Detects a hung hopper, latches a fault, and stops paying.

Parameters:
- DEPTH, 4, transaction FIFO entries; power of 2, 2..16.
- VEND_CYCLES, 4, cycles vend_motor is held high per purchase; 1..255.
- ACK_TIMEOUT, 16, max cycles spent waiting in any one handshake phase before fault; 1..255.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- txn_valid  input  1  one-cycle strobe: purchase/cash_return below are a completed transaction.
- purchase  input  1  1 = product to be vended.
- cash_return  input  2  change code: 00=R0, 01=R5, 10=R10, 11=R15; value = number of 5-unit coins.
- coin_ack  input  1  hopper acknowledge.
- coin_req  output  1  hopper request; one coin per full req/ack cycle.
- vend_motor  output  1  product motor drive.
- busy  output  1  FSM not in IDLE.
- fifo_full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  sticky: a transaction was dropped.
- hopper_fault  output  1  sticky: handshake timeout.
- coins_paid  output  8  total coins dispensed; wraps 255->0.

Behaviour:
- Reset (async, any state, mid-handshake included):
  - FIFO emptied; FSM to IDLE.
  - Every output goes to 0 immediately, including coins_paid, overflow and hopper_fault.
  - In-flight transaction is lost.
- Enqueue, at a clock edge where txn_valid=1:
  - Entry {purchase, cash_return}=000 is a no-op and is not stored.
  - Otherwise, if not full, the entry is written.
  - If full, the entry is dropped and overflow is set.
  - Fullness is judged before the same-cycle pop, so txn_valid on full with a simultaneous pop is still dropped.
- All outputs are registered or Moore-decoded from state: coin_req=1 only in COIN_REQ; vend_motor=1 only in VEND.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into working regs (vend flag, coin count 0..3), then LOAD.
  - LOAD: if vend flag, go to VEND; else if count>0, go to COIN_REQ; else go to IDLE.
  - VEND: stay exactly VEND_CYCLES cycles, then go to COIN_REQ if count>0, else IDLE.
  - COIN_REQ: hold coin_req=1.
    - coin_ack=1 -> COIN_REL.
    - Timer reaching ACK_TIMEOUT cycles without ack -> FAULT.
  - COIN_REL: coin_req=0; wait for coin_ack=0.
    - On exit: count-1, coins_paid+1; go to IDLE if the new count is 0, else COIN_REQ.
    - Timeout -> FAULT.
  - FAULT: hopper_fault=1, coin_req=0, vend_motor=0. Absorbing until reset. FIFO keeps accepting until full; remaining coins of the current transaction are abandoned.
- Timer restarts on entry to COIN_REQ and to COIN_REL.
- An ack already high on entry to COIN_REQ is accepted next cycle.
- Latency: txn_valid at edge N -> pop at edge N+1 -> LOAD -> VEND at edge N+2; vend_motor high for edges N+2..N+2+VEND_CYCLES-1.
- busy is high from the pop until return to IDLE, and is also high in FAULT.
- Back-to-back transactions: a minimum of 1 IDLE cycle between transactions.
- Pointer wrap: read and write pointers wrap modulo DEPTH; full/empty are derived from an occupancy count 0..DEPTH.

Test Plan:
- Reset, then txn_valid with purchase=1, cash_return=00 -> vend_motor high exactly 4 cycles starting 2 edges after the strobe; coin_req never rises; coins_paid=0; busy then low.
- purchase=1, cash_return=11, hopper acks 2 cycles after each req and drops ack 1 cycle after req falls -> 4 vend cycles, then exactly 3 req/ack cycles; coins_paid=3; FIFO empty.
- Five non-zero transactions strobed on consecutive cycles while FSM busy (DEPTH=4) -> fifo_full=1 after the 4th; 5th dropped; overflow=1; exactly 4 transactions served in order.
- purchase=0, cash_return=10, coin_ack held 0 -> coin_req high for 16 cycles, then hopper_fault=1, coin_req=0, coins_paid=0; FSM stays in FAULT.
- Async reset asserted mid-COIN_REQ with 2 entries queued -> coin_req, busy and fifo_full drop without a clock edge; after release the FIFO is empty and coins_paid=0.
- txn_valid with 000, plus coins_paid wrap (preload by paying 256 coins) -> 000 is not queued and busy stays 0; coins_paid wraps 255->0.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser
// Sits behind the vending-controller FSM. Each completed transaction goes into
// a small FIFO. Entries are then served one at a time: the product motor runs
// for VEND_CYCLES, and change is paid as 5-unit coins over a four-phase
// req/ack handshake with the coin hopper. If the hopper stalls in any
// handshake phase for ACK_TIMEOUT cycles, the block latches a fault and stops.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset, clears all state
//   txn_valid    one-cycle strobe qualifying purchase/cash_return
//   purchase     1 = vend a product
//   cash_return  change code, value = number of 5-unit coins (0..3)
//   coin_ack     hopper acknowledge
//   coin_req     hopper request, one coin per full req/ack cycle
//   vend_motor   product motor drive
//   busy         FSM not idle
//   fifo_full    FIFO holds DEPTH entries
//   overflow     sticky, a transaction was dropped on a full FIFO
//   hopper_fault sticky, handshake timeout
//   coins_paid   running count of dispensed coins, wraps 255->0
module change_dispenser #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned VEND_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       txn_valid,
  input  logic       purchase,
  input  logic [1:0] cash_return,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic       vend_motor,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow,
  output logic       hopper_fault,
  output logic [7:0] coins_paid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [7:0]  VEND_LAST = 8'(VEND_CYCLES - 1);
  localparam logic [7:0]  ACK_LAST  = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VEND,
    S_COIN_REQ,
    S_COIN_REL,
    S_FAULT
  } state_t;

  state_t r_state, w_state_nx;

  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          r_vend,  w_vend_nx;
  logic [1:0]    r_coins, w_coins_nx;
  logic [7:0]    r_timer, w_timer_nx;
  logic [7:0]    r_paid,  w_paid_nx;

  logic [2:0]    w_entry, w_head;
  logic          w_full, w_empty, w_push_req, w_push, w_pop;

  assign w_entry    = {purchase, cash_return};
  assign w_head     = r_mem[r_rptr];
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  // An all-zero entry carries no work, so it never occupies a slot.
  assign w_push_req = txn_valid && (w_entry != '0);
  // Fullness is the registered occupancy, so a same-cycle pop does not make room.
  assign w_push     = w_push_req && !w_full;
  assign w_pop      = (r_state == S_IDLE) && !w_empty;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_vend  <= 1'b0;
      r_coins <= '0;
      r_timer <= '0;
      r_paid  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_vend  <= w_vend_nx;
      r_coins <= w_coins_nx;
      r_timer <= w_timer_nx;
      r_paid  <= w_paid_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_vend_nx  = r_vend;
    w_coins_nx = r_coins;
    w_timer_nx = r_timer;
    w_paid_nx  = r_paid;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_vend_nx  = w_head[2];
          w_coins_nx = w_head[1:0];
          w_state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        w_timer_nx = '0;
        if (r_vend)              w_state_nx = S_VEND;
        else if (r_coins != '0)  w_state_nx = S_COIN_REQ;
        else                     w_state_nx = S_IDLE;
      end
      S_VEND: begin
        if (r_timer == VEND_LAST) begin
          w_timer_nx = '0;
          w_state_nx = (r_coins != '0) ? S_COIN_REQ : S_IDLE;
        end else begin
          w_timer_nx = r_timer + 8'd1;
        end
      end
      S_COIN_REQ: begin
        if (coin_ack) begin
          w_timer_nx = '0;
          w_state_nx = S_COIN_REL;
        end else if (r_timer == ACK_LAST) begin
          w_state_nx = S_FAULT;
        end else begin
          w_timer_nx = r_timer + 8'd1;
        end
      end
      S_COIN_REL: begin
        if (!coin_ack) begin
          w_timer_nx = '0;
          w_coins_nx = r_coins - 2'd1;
          w_paid_nx  = r_paid + 8'd1;
          w_state_nx = (r_coins == 2'd1) ? S_IDLE : S_COIN_REQ;
        end else if (r_timer == ACK_LAST) begin
          w_state_nx = S_FAULT;
        end else begin
          w_timer_nx = r_timer + 8'd1;
        end
      end
      S_FAULT: w_state_nx = S_FAULT;
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign coin_req     = (r_state == S_COIN_REQ);
  assign vend_motor   = (r_state == S_VEND);
  assign busy         = (r_state != S_IDLE);
  assign hopper_fault = (r_state == S_FAULT);
  assign fifo_full    = w_full;
  assign overflow     = r_overflow;
  assign coins_paid   = r_paid;

endmodule
